// File: rtl/jtdd_mailbox.sv
// jtdd_mailbox: communication block between the main CPU and the sub CPU.
// It holds a dual-port shared RAM, a first-word fall-through command FIFO
// (main pushes, sub pops), and two interrupt handshakes
// (main -> sub NMI, sub -> main IRQ) with an optional timeout.
//
// Build option: define JTDD_MBOX_BAN_EN to enable the sub bus ban.
// With it, sub_ban follows main_cs from the previous main-enabled cycle.
// While sub_ban is set, sub RAM writes are dropped and sub_dout holds.
// Without it, sub_ban is tied to 0.
//
// Ports (all actions are qualified by the owning side's clock enable):
//   clk, rstn                 clock, asynchronous active-low reset
//   cen_main, cen_sub         per-side clock enables
//   main_addr/din/cs/we/dout  main RAM port (1-cycle read latency)
//   main_lat_we               push main_din into the command FIFO
//   main_nmi_set              raise sub_nmi
//   main_irq, main_irq_ack    interrupt to main and its clear
//   fifo_full, overflow       FIFO full, sticky "push dropped"
//   sub_addr/din/cs/we/dout   sub RAM port (1-cycle read latency)
//   sub_lat_rd                pop the FIFO
//   sub_lat_dout/valid        FIFO head and not-empty flag
//   sub_nmi, sub_nmi_ack      interrupt to sub and its clear
//   sub_irqmain_set           raise main_irq
//   sub_ban                   sub bus ban (0 unless JTDD_MBOX_BAN_EN)
module jtdd_mailbox #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int FIFO_AW = 2,
  parameter int TOUT    = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen_main,
  input  logic          cen_sub,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_din,
  input  logic          main_cs,
  input  logic          main_we,
  output logic [DW-1:0] main_dout,
  input  logic          main_lat_we,
  input  logic          main_nmi_set,
  output logic          main_irq,
  input  logic          main_irq_ack,
  output logic          fifo_full,
  output logic          overflow,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_din,
  input  logic          sub_cs,
  input  logic          sub_we,
  output logic [DW-1:0] sub_dout,
  input  logic          sub_lat_rd,
  output logic [DW-1:0] sub_lat_dout,
  output logic          sub_lat_valid,
  output logic          sub_nmi,
  input  logic          sub_nmi_ack,
  input  logic          sub_irqmain_set,
  output logic          sub_ban
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [CW-1:0]    TLAST    = (TOUT > 0) ? CW'(TOUT - 1) : '0;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} irq_state_t;

  // ---------------- sub bus ban ----------------
  logic ban_s;
`ifdef JTDD_MBOX_BAN_EN
  logic ban_q;
  // Ban tracks main_cs as seen on the previous main-enabled cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ban_q <= 1'b0;
    end else if (cen_main) begin
      ban_q <= main_cs;
    end
  end
  assign ban_s = ban_q;
`else
  assign ban_s = 1'b0;
`endif
  assign sub_ban = ban_s;

  // ---------------- shared RAM ----------------
  logic [DW-1:0] ram_q [0:(1<<AW)-1];
  logic [DW-1:0] main_dout_q, sub_dout_q;
  logic main_wr_s, sub_wr_s;

  assign main_wr_s = cen_main & main_cs & main_we;
  assign sub_wr_s  = cen_sub & sub_cs & sub_we & ~ban_s;

  // RAM array; the main write is issued last so it wins an address collision
  always_ff @(posedge clk) begin
    if (sub_wr_s)  ram_q[sub_addr]  <= sub_din;
    if (main_wr_s) ram_q[main_addr] <= main_din;
  end

  // Registered read ports (old data on read-during-write)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_dout_q <= '0;
      sub_dout_q  <= '0;
    end else begin
      if (cen_main && main_cs)           main_dout_q <= ram_q[main_addr];
      if (cen_sub && sub_cs && !ban_s)   sub_dout_q  <= ram_q[sub_addr];
    end
  end
  assign main_dout = main_dout_q;
  assign sub_dout  = sub_dout_q;

  // ---------------- command FIFO ----------------
  logic [DW-1:0]      fifo_q [0:DEPTH-1];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               push_s, pop_s, drop_s;
  logic [DW-1:0]      head_d;
  logic               full_q, ovf_q, valid_q;
  logic [DW-1:0]      lat_dout_q;

  // Push/pop qualification; a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    pop_s    = cen_sub & sub_lat_rd & (cnt_q != '0);
    push_s   = cen_main & main_lat_we & ((cnt_q != FULL_CNT) | pop_s);
    drop_s   = cen_main & main_lat_we & ~push_s;
    cnt_d    = cnt_q + {{FIFO_AW{1'b0}}, push_s} - {{FIFO_AW{1'b0}}, pop_s};
    rd_ptr_d = pop_s ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    // When the only remaining entry is the one written now, bypass the array
    if (push_s && (cnt_q == {{FIFO_AW{1'b0}}, pop_s})) begin
      head_d = main_din;
    end else begin
      head_d = fifo_q[rd_ptr_d];
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) fifo_q[wr_ptr_q] <= main_din;
  end

  // FIFO pointers, occupancy and registered status/head outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      lat_dout_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == FULL_CNT);
      valid_q  <= (cnt_d != '0);
      if (drop_s)         ovf_q      <= 1'b1;
      if (cnt_d != '0)    lat_dout_q <= head_d;
    end
  end
  assign fifo_full     = full_q;
  assign overflow      = ovf_q;
  assign sub_lat_valid = valid_q;
  assign sub_lat_dout  = lat_dout_q;

  // ---------------- interrupt handshakes ----------------
  irq_state_t      nmi_st_q, irq_st_q;
  logic [CW-1:0]   nmi_cnt_q, irq_cnt_q;

  // main -> sub NMI; timeout counts sub-enabled cycles. Set beats ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nmi_st_q  <= IDLE;
      nmi_cnt_q <= '0;
    end else begin
      case (nmi_st_q)
        IDLE: if (cen_main && main_nmi_set) begin
          nmi_st_q  <= PEND;
          nmi_cnt_q <= '0;
        end
        PEND: if (cen_main && main_nmi_set) begin
          nmi_cnt_q <= '0;
        end else if (cen_sub && sub_nmi_ack) begin
          nmi_st_q  <= IDLE;
        end else if (cen_sub && (TOUT != 0)) begin
          if (nmi_cnt_q == TLAST) begin
            nmi_st_q  <= IDLE;
            nmi_cnt_q <= '0;
          end else begin
            nmi_cnt_q <= nmi_cnt_q + CW'(1);
          end
        end
        default: nmi_st_q <= IDLE;
      endcase
    end
  end
  assign sub_nmi = (nmi_st_q == PEND);

  // sub -> main IRQ; timeout counts main-enabled cycles. Set beats ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_st_q  <= IDLE;
      irq_cnt_q <= '0;
    end else begin
      case (irq_st_q)
        IDLE: if (cen_sub && sub_irqmain_set) begin
          irq_st_q  <= PEND;
          irq_cnt_q <= '0;
        end
        PEND: if (cen_sub && sub_irqmain_set) begin
          irq_cnt_q <= '0;
        end else if (cen_main && main_irq_ack) begin
          irq_st_q  <= IDLE;
        end else if (cen_main && (TOUT != 0)) begin
          if (irq_cnt_q == TLAST) begin
            irq_st_q  <= IDLE;
            irq_cnt_q <= '0;
          end else begin
            irq_cnt_q <= irq_cnt_q + CW'(1);
          end
        end
        default: irq_st_q <= IDLE;
      endcase
    end
  end
  assign main_irq = (irq_st_q == PEND);

endmodule

// File: tb/tb_jtdd_mailbox.sv
module tb_jtdd_mailbox;

  logic       clk, rstn, cen_main, cen_sub;
  logic [8:0] main_addr, sub_addr;
  logic [7:0] main_din, sub_din;
  logic       main_cs, main_we, main_lat_we, main_nmi_set, main_irq_ack;
  logic       sub_cs, sub_we, sub_lat_rd, sub_nmi_ack, sub_irqmain_set;
  logic [7:0] main_dout, sub_dout, sub_lat_dout;
  logic       main_irq, fifo_full, overflow, sub_lat_valid, sub_nmi, sub_ban;
  // second instance with the timeout enabled
  logic [7:0] t_main_dout, t_sub_dout, t_sub_lat_dout;
  logic       t_main_irq, t_fifo_full, t_overflow, t_sub_lat_valid, t_sub_nmi, t_sub_ban;

  jtdd_mailbox dut (
    .clk(clk), .rstn(rstn), .cen_main(cen_main), .cen_sub(cen_sub),
    .main_addr(main_addr), .main_din(main_din), .main_cs(main_cs), .main_we(main_we),
    .main_dout(main_dout), .main_lat_we(main_lat_we), .main_nmi_set(main_nmi_set),
    .main_irq(main_irq), .main_irq_ack(main_irq_ack), .fifo_full(fifo_full),
    .overflow(overflow), .sub_addr(sub_addr), .sub_din(sub_din), .sub_cs(sub_cs),
    .sub_we(sub_we), .sub_dout(sub_dout), .sub_lat_rd(sub_lat_rd),
    .sub_lat_dout(sub_lat_dout), .sub_lat_valid(sub_lat_valid), .sub_nmi(sub_nmi),
    .sub_nmi_ack(sub_nmi_ack), .sub_irqmain_set(sub_irqmain_set), .sub_ban(sub_ban)
  );

  jtdd_mailbox #(.TOUT(8)) dut_t (
    .clk(clk), .rstn(rstn), .cen_main(cen_main), .cen_sub(cen_sub),
    .main_addr(main_addr), .main_din(main_din), .main_cs(main_cs), .main_we(main_we),
    .main_dout(t_main_dout), .main_lat_we(main_lat_we), .main_nmi_set(main_nmi_set),
    .main_irq(t_main_irq), .main_irq_ack(main_irq_ack), .fifo_full(t_fifo_full),
    .overflow(t_overflow), .sub_addr(sub_addr), .sub_din(sub_din), .sub_cs(sub_cs),
    .sub_we(sub_we), .sub_dout(t_sub_dout), .sub_lat_rd(sub_lat_rd),
    .sub_lat_dout(t_sub_lat_dout), .sub_lat_valid(t_sub_lat_valid), .sub_nmi(t_sub_nmi),
    .sub_nmi_ack(sub_nmi_ack), .sub_irqmain_set(sub_irqmain_set), .sub_ban(t_sub_ban)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] K_MW = 3'd0, K_SW = 3'd1, K_MR = 3'd2, K_SR = 3'd3,
                         K_CW = 3'd4, K_MWR = 3'd5;

  typedef struct {
    logic [2:0] kind;
    logic [8:0] addr;
    logic [7:0] mdata;
    logic [7:0] sdata;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] mq [$];   // expected main_dout values
  logic [7:0] sq [$];   // expected sub_dout values
  logic [7:0] fq [$];   // FIFO model contents
  logic       ovf_exp;
  logic [7:0] last_pop;
  int         n_cmp, n_bad;

`ifdef JTDD_MBOX_BAN_EN
  localparam bit BAN = 1'b1;
`else
  localparam bit BAN = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    main_cs = 1'b0; main_we = 1'b0; main_lat_we = 1'b0; main_nmi_set = 1'b0;
    main_irq_ack = 1'b0; sub_cs = 1'b0; sub_we = 1'b0; sub_lat_rd = 1'b0;
    sub_nmi_ack = 1'b0; sub_irqmain_set = 1'b0;
  endtask

  // One FIFO operation, checked against the queue model
  task automatic fifo_op(input logic push, input logic [7:0] val, input logic pop, input string nm);
    logic popped;
    popped = pop && (fq.size() > 0);
    if (popped) begin
      check({nm, "_head"}, sub_lat_dout, fq[0]);
      last_pop = fq.pop_front();
    end
    if (push) begin
      if (fq.size() < 4) fq.push_back(val);
      else ovf_exp = 1'b1;
    end
    main_lat_we = push; main_din = val; sub_lat_rd = pop;
    tick();
    main_lat_we = 1'b0; sub_lat_rd = 1'b0;
    check({nm, "_valid"}, sub_lat_valid, fq.size() != 0);
    check({nm, "_full"}, fifo_full, fq.size() == 4);
    check({nm, "_ovf"}, overflow, ovf_exp);
    if (fq.size() != 0) check({nm, "_dout"}, sub_lat_dout, fq[0]);
  endtask

  initial begin
    int lows, hi;
    logic [7:0] e;
    n_cmp = 0; n_bad = 0; ovf_exp = 1'b0; last_pop = 8'h00;
    rstn = 1'b0; cen_main = 1'b1; cen_sub = 1'b1;
    main_addr = 9'h000; sub_addr = 9'h000; main_din = 8'h00; sub_din = 8'h00;
    idle_inputs();

    vecs[0]  = '{K_MW,  9'h1FF, 8'hA5, 8'h00, 8'h00, "mw_1ff"};
    vecs[1]  = '{K_SR,  9'h1FF, 8'h00, 8'h00, 8'hA5, "sr_1ff"};
    vecs[2]  = '{K_SW,  9'h000, 8'h00, 8'h3C, 8'h00, "sw_000"};
    vecs[3]  = '{K_MR,  9'h000, 8'h00, 8'h00, 8'h3C, "mr_000"};
    vecs[4]  = '{K_CW,  9'h040, 8'h11, 8'h22, 8'h00, "collide"};
    vecs[5]  = '{K_MR,  9'h040, 8'h00, 8'h00, 8'h11, "mr_040"};
    vecs[6]  = '{K_SR,  9'h040, 8'h00, 8'h00, 8'h11, "sr_040"};
    vecs[7]  = '{K_MW,  9'h050, 8'hAA, 8'h00, 8'h00, "mw_050"};
    vecs[8]  = '{K_MWR, 9'h050, 8'hBB, 8'h00, 8'hAA, "rdw_old"};
    vecs[9]  = '{K_SR,  9'h050, 8'h00, 8'h00, 8'hBB, "sr_050"};
    vecs[10] = '{K_MR,  9'h1FF, 8'h00, 8'h00, 8'hA5, "mr_1ff"};

    // reset state
    #12;
    check("rst_data", {8'h00, main_dout, sub_dout, sub_lat_dout}, 32'h0);
    check("rst_flags", {main_irq, sub_nmi, fifo_full, overflow, sub_lat_valid, sub_ban}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // RAM vectors, each followed by an idle cycle so sub_ban is clear
    for (int i = 0; i < 11; i++) begin
      main_addr = vecs[i].addr; sub_addr = vecs[i].addr;
      main_din = vecs[i].mdata; sub_din = vecs[i].sdata;
      main_cs = (vecs[i].kind inside {K_MW, K_MR, K_CW, K_MWR});
      main_we = (vecs[i].kind inside {K_MW, K_CW, K_MWR});
      sub_cs  = (vecs[i].kind inside {K_SW, K_SR, K_CW});
      sub_we  = (vecs[i].kind inside {K_SW, K_CW});
      if (vecs[i].kind inside {K_MR, K_MWR}) mq.push_back(vecs[i].exp);
      if (vecs[i].kind == K_SR) sq.push_back(vecs[i].exp);
      tick();
      idle_inputs();
      if (vecs[i].kind inside {K_MR, K_MWR}) begin
        e = mq.pop_front();
        check(vecs[i].name, main_dout, e);
      end
      if (vecs[i].kind == K_SR) begin
        e = sq.pop_front();
        check(vecs[i].name, sub_dout, e);
      end
      tick();
    end

    // bus ban: sub writes 0x77 to 0x010 while main holds main_cs
    main_cs = 1'b1; main_we = 1'b1; main_addr = 9'h010; main_din = 8'h66;
    tick(); idle_inputs(); tick();
    sub_cs = 1'b1; sub_addr = 9'h1FF;
    tick(); idle_inputs();
    check("ban_pre_sr", sub_dout, 8'hA5);
    tick();
    main_cs = 1'b1; main_addr = 9'h000;
    tick();
    sub_cs = 1'b1; sub_we = 1'b1; sub_addr = 9'h010; sub_din = 8'h77;
    tick();
    check("ban_flag", sub_ban, BAN);
    check("ban_sub_dout", sub_dout, BAN ? 8'hA5 : 8'h66);
    idle_inputs(); tick(); tick();
    main_cs = 1'b1; main_addr = 9'h010;
    tick(); idle_inputs();
    check("ban_ram", main_dout, BAN ? 8'h66 : 8'h77);
    tick();

    // FIFO fill, overflow and ordered drain
    for (int i = 1; i <= 4; i++) fifo_op(1'b1, 8'(i), 1'b0, "fill");
    fifo_op(1'b1, 8'h05, 1'b0, "push_full");
    for (int i = 0; i < 4; i++) fifo_op(1'b0, 8'h00, 1'b1, "drain");
    check("drain_last", last_pop, 8'h04);

    // interrupt handshake, no timeout
    main_nmi_set = 1'b1; tick(); main_nmi_set = 1'b0;
    check("nmi_set", sub_nmi, 1'b1);
    lows = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (!sub_nmi) lows++;
    end
    check("nmi_hold1000", lows, 0);
    cen_sub = 1'b0; sub_nmi_ack = 1'b1; tick();
    check("nmi_ack_gated", sub_nmi, 1'b1);
    cen_sub = 1'b1; tick(); sub_nmi_ack = 1'b0;
    check("nmi_ack", sub_nmi, 1'b0);
    main_nmi_set = 1'b1; sub_nmi_ack = 1'b1; tick(); idle_inputs();
    check("nmi_set_ack", sub_nmi, 1'b1);
    sub_nmi_ack = 1'b1; tick(); idle_inputs();
    check("nmi_ack2", sub_nmi, 1'b0);
    sub_irqmain_set = 1'b1; tick(); idle_inputs();
    check("irq_set", main_irq, 1'b1);
    main_irq_ack = 1'b1; tick(); idle_inputs();
    check("irq_ack", main_irq, 1'b0);
    check("irq_t_ack", t_main_irq, 1'b0);

    // asynchronous reset in the middle of activity
    fifo_op(1'b1, 8'h42, 1'b0, "pre_rst");
    main_nmi_set = 1'b1; main_cs = 1'b1; main_addr = 9'h1FF;
    tick(); idle_inputs();
    check("pre_rst_state", {sub_lat_valid, sub_nmi, main_dout}, {2'b11, 8'hA5});
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_data", {8'h00, main_dout, sub_dout, sub_lat_dout}, 32'h0);
    check("rst_mid_flags", {main_irq, sub_nmi, fifo_full, overflow, sub_lat_valid, sub_ban}, 32'h0);
    #1 rstn = 1'b1;
    fq.delete(); ovf_exp = 1'b0;
    tick();

    // FIFO corner cases
    for (int i = 1; i <= 4; i++) fifo_op(1'b1, 8'(i), 1'b0, "refill");
    fifo_op(1'b1, 8'h09, 1'b1, "full_pushpop");
    check("pushpop_popped", last_pop, 8'h01);
    for (int i = 0; i < 4; i++) fifo_op(1'b0, 8'h00, 1'b1, "drain2");
    check("drain2_tail", last_pop, 8'h09);
    fifo_op(1'b0, 8'h00, 1'b1, "pop_empty");
    check("pop_empty_dout", sub_lat_dout, last_pop);
    fifo_op(1'b1, 8'h33, 1'b1, "empty_pushpop");

    // timeout on the TOUT=8 instance, then a re-set while pending
    sub_irqmain_set = 1'b1; tick(); sub_irqmain_set = 1'b0;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (t_main_irq) hi++;
      tick();
    end
    check("tout_cycles", hi, 8);
    sub_irqmain_set = 1'b1; tick(); sub_irqmain_set = 1'b0;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      if (t_main_irq) hi++;
      sub_irqmain_set = (k == 4);
      tick();
    end
    sub_irqmain_set = 1'b0;
    check("tout_restart", hi, 13);
    check("tout0_still_pend", main_irq, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
